// File: rtl/lpm_period_capture.sv
// Period / high-width capture: synchronizes sig_in, then counts clk_en-qualified
// cycles from a rising edge to the terminating edge and holds the result until consumed.
module lpm_period_capture #(
    parameter int unsigned lpm_width       = 16,
    parameter int unsigned lpm_sync_stages = 2
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 sig_in,
    input  logic                 clk_en,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 rd_ack,
    output logic [lpm_width-1:0] q,
    output logic                 valid,
    output logic                 busy,
    output logic                 overflow
);

    localparam int unsigned W = lpm_width;
    localparam int unsigned S = lpm_sync_stages;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t         state, state_nx;
    logic [S-1:0]   sync_ff;
    logic           hist;
    logic           rise, fall, term;
    logic [W-1:0]   cnt, cnt_nx, cnt_inc, q_nx;
    logic           sat, sat_nx, sat_step;
    logic           valid_nx, ovf_nx, busy_nx;
    logic           mode_r, mode_nx;

    // Synchronizer chain plus history flop for edge detection
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            sync_ff <= '0;
            hist    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[S-2:0], sig_in};
            hist    <= sync_ff[S-1];
        end
    end

    assign rise = sync_ff[S-1] & ~hist;
    assign fall = ~sync_ff[S-1] & hist;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state    <= IDLE;
            cnt      <= '0;
            sat      <= 1'b0;
            q        <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            mode_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            sat      <= sat_nx;
            q        <= q_nx;
            valid    <= valid_nx;
            overflow <= ovf_nx;
            busy     <= busy_nx;
            mode_r   <= mode_nx;
        end
    end

    // Saturating increment; an attempt at all-ones marks the measurement as overflowed
    always_comb begin
        cnt_inc  = (clk_en && !(&cnt)) ? cnt + W'(1) : cnt;
        sat_step = sat | (clk_en & (&cnt));
        term     = mode_r ? fall : rise;

        state_nx = state;
        cnt_nx   = cnt;
        sat_nx   = sat;
        q_nx     = q;
        valid_nx = valid;
        ovf_nx   = overflow;
        mode_nx  = mode_r;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = ARM;
                    mode_nx  = mode;
                    valid_nx = 1'b0;
                    ovf_nx   = 1'b0;
                end else if (state == DONE && rd_ack) begin
                    state_nx = IDLE;
                    valid_nx = 1'b0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = '0;
                    sat_nx   = 1'b0;
                end
            end
            MEASURE: begin
                cnt_nx = cnt_inc;
                sat_nx = sat_step;
                if (term) begin
                    state_nx = DONE;
                    q_nx     = cnt_inc;
                    valid_nx = 1'b1;
                    ovf_nx   = sat_step;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == ARM) || (state_nx == MEASURE);
    end

endmodule

// File: tb/tb_lpm_period_capture.sv
// Bench for lpm_period_capture: a 16-bit and a 4-bit instance share stimulus and are
// compared every cycle against an event-level reference model, plus table and directed scenarios.
module tb_lpm_period_capture;

    localparam int S = 2;
    localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_DONE = 3;

    logic        clock, aclr_n, sig_in, clk_en, start, mode, rd_ack;
    logic [15:0] q16;
    logic [3:0]  q4;
    logic        valid16, busy16, ovf16, valid4, busy4, ovf4;

    int n_tests = 0;
    int n_fail  = 0;

    lpm_period_capture #(.lpm_width(16), .lpm_sync_stages(S)) u_dut16 (
        .clock(clock), .aclr_n(aclr_n), .sig_in(sig_in), .clk_en(clk_en), .start(start),
        .mode(mode), .rd_ack(rd_ack), .q(q16), .valid(valid16), .busy(busy16), .overflow(ovf16)
    );

    lpm_period_capture #(.lpm_width(4), .lpm_sync_stages(S)) u_dut4 (
        .clock(clock), .aclr_n(aclr_n), .sig_in(sig_in), .clk_en(clk_en), .start(start),
        .mode(mode), .rd_ack(rd_ack), .q(q4), .valid(valid4), .busy(busy4), .overflow(ovf4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: unbounded count, clamped per width only when reported
    bit dq[$];
    int m_ph;
    bit m_mode, m_valid, m_reported;
    int m_cnt, m_q;

    task automatic model_reset();
        dq.delete();
        for (int i = 0; i < S + 2; i++) dq.push_back(1'b0);
        m_ph = M_IDLE; m_mode = 0; m_valid = 0; m_reported = 0; m_cnt = 0; m_q = 0;
    endtask

    task automatic model_step();
        bit s_now, s_prev, rise, fall, term;
        if (!aclr_n) begin
            model_reset();
            return;
        end
        dq.push_back(sig_in);
        void'(dq.pop_front());
        s_now  = dq[dq.size() - 1 - S];
        s_prev = dq[dq.size() - 2 - S];
        rise   = s_now && !s_prev;
        fall   = !s_now && s_prev;
        case (m_ph)
            M_ARM: if (rise) begin m_ph = M_MEAS; m_cnt = 0; end
            M_MEAS: begin
                if (clk_en) m_cnt++;
                term = m_mode ? fall : rise;
                if (term) begin
                    m_q = m_cnt; m_valid = 1; m_reported = 1; m_ph = M_DONE;
                end
            end
            default: begin
                if (start) begin
                    m_ph = M_ARM; m_mode = mode; m_valid = 0; m_reported = 0;
                end else if (m_ph == M_DONE && rd_ack) begin
                    m_ph = M_IDLE; m_valid = 0;
                end
            end
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit eb;
        eb = (m_ph == M_ARM) || (m_ph == M_MEAS);
        chk({tag, ".q16"},     int'(q16),     (m_q > 65535) ? 65535 : m_q);
        chk({tag, ".valid16"}, int'(valid16), int'(m_valid));
        chk({tag, ".busy16"},  int'(busy16),  int'(eb));
        chk({tag, ".ovf16"},   int'(ovf16),   int'(m_reported && m_q > 65535));
        chk({tag, ".q4"},      int'(q4),      (m_q > 15) ? 15 : m_q);
        chk({tag, ".valid4"},  int'(valid4),  int'(m_valid));
        chk({tag, ".busy4"},   int'(busy4),   int'(eb));
        chk({tag, ".ovf4"},    int'(ovf4),    int'(m_reported && m_q > 15));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check_outputs("cyc");
    endtask

    task automatic tick_en(input bit alt);
        clk_en = alt ? ~clk_en : 1'b1;
        tick();
    endtask

    task automatic run_wave(input bit md, input int hi, input int lo, input bit alt);
        mode = md; start = 1; tick(); start = 0;
        sig_in = 0;
        repeat (3) tick_en(alt);
        for (int r = 0; r < 3; r++) begin
            sig_in = 1; repeat (hi) tick_en(alt);
            sig_in = 0; repeat (lo) tick_en(alt);
        end
        clk_en = 1;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 200 && !valid16; i++) tick();
        chk({nm, ".valid_timeout"}, int'(valid16), 1);
    endtask

    typedef struct {
        bit md; int hi; int lo; bit alt;
        int exp_q16; int exp_q4; bit exp_ovf4;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{0,  5,  5, 0, 10, 10, 0};
        tbl[1] = '{1,  7,  6, 0,  7,  7, 0};
        tbl[2] = '{0, 10, 10, 1, 10, 10, 0};
        tbl[3] = '{0, 20, 20, 0, 40, 15, 1};
        tbl[4] = '{0,  7,  8, 0, 15, 15, 0};
        tbl[5] = '{0,  8,  8, 0, 16, 15, 1};
        tbl[6] = '{1,  1,  3, 0,  1,  1, 0};
        tbl[7] = '{0,  1,  1, 0,  2,  2, 0};
        tbl[8] = '{1, 16,  4, 0, 16, 15, 1};

        aclr_n = 0; sig_in = 0; clk_en = 1; start = 0; mode = 0; rd_ack = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset");
        aclr_n = 1;
        repeat (3) tick();

        // Table-driven measurements
        for (int i = 0; i < 9; i++) begin
            run_wave(tbl[i].md, tbl[i].hi, tbl[i].lo, tbl[i].alt);
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.q16", i),   int'(q16),   tbl[i].exp_q16);
            chk($sformatf("vec%0d.q4", i),    int'(q4),    tbl[i].exp_q4);
            chk($sformatf("vec%0d.ovf4", i),  int'(ovf4),  int'(tbl[i].exp_ovf4));
            chk($sformatf("vec%0d.ovf16", i), int'(ovf16), 0);
            chk($sformatf("vec%0d.busy", i),  int'(busy16), 0);
            rd_ack = 1; tick(); rd_ack = 0;
            tick();
        end

        // Handshake: hold, acknowledge, then start+rd_ack together
        run_wave(0, 5, 5, 0);
        wait_valid("hs");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hs.hold_q", int'(q16), 10);
            chk("hs.hold_valid", int'(valid16), 1);
        end
        rd_ack = 1; tick(); rd_ack = 0;
        chk("hs.ack_valid", int'(valid16), 0);
        chk("hs.ack_busy", int'(busy16), 0);
        chk("hs.ack_q", int'(q16), 10);
        rd_ack = 1; tick(); rd_ack = 0;
        run_wave(0, 3, 3, 0);
        wait_valid("hs2");
        start = 1; rd_ack = 1; tick(); start = 0; rd_ack = 0;
        chk("hs.both_busy", int'(busy16), 1);
        chk("hs.both_valid", int'(valid16), 0);
        start = 1; tick(); start = 0;
        chk("hs.start_in_arm", int'(busy16), 1);
        sig_in = 1; repeat (4) tick(); sig_in = 0; repeat (4) tick();
        sig_in = 1; repeat (4) tick(); sig_in = 0;
        wait_valid("hs3");
        chk("hs3.q", int'(q16), 8);
        rd_ack = 1; tick(); rd_ack = 0;

        // Mode change after arming has no effect
        mode = 1; start = 1; tick(); start = 0; mode = 0;
        sig_in = 0; repeat (2) tick();
        sig_in = 1; repeat (4) tick(); sig_in = 0; repeat (6) tick();
        wait_valid("modechg");
        chk("modechg.q", int'(q16), 4);
        rd_ack = 1; tick(); rd_ack = 0;

        // Reset mid-measurement, released with sig_in high
        mode = 0; start = 1; tick(); start = 0;
        sig_in = 0; repeat (3) tick();
        sig_in = 1; repeat (5) tick();
        chk("rst.pre_busy", int'(busy16), 1);
        #2;
        aclr_n = 0;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (2) tick();
        aclr_n = 1;
        repeat (8) tick();
        chk("rst.post_busy", int'(busy16), 0);
        chk("rst.post_valid", int'(valid16), 0);
        sig_in = 0;

        // Randomized traffic checked against the model every cycle
        for (int c = 0; c < 3000; c++) begin
            start  = ($urandom_range(0, 15) == 0);
            rd_ack = ($urandom_range(0, 7) == 0);
            mode   = 1'($urandom_range(0, 1));
            clk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) sig_in = ~sig_in;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lpm_period_capture.md
LPM_PERIOD_CAPTURE -- requirements
Module: lpm_period_capture

Interface
REQ-001 The block SHALL have parameter lpm_width, default 16, giving the width of the measured count (valid range 2..32).
REQ-002 The block SHALL have parameter lpm_sync_stages, default 2, giving the number of sig_in synchronizer flops (valid range 2..4).
REQ-003 The block SHALL have port clock, input, 1 bit: single rising-edge clock for all state.
REQ-004 The block SHALL have port aclr_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sig_in, input, 1 bit: asynchronous signal to be measured.
REQ-006 The block SHALL have port clk_en, input, 1 bit: qualifies count increments only; edge detection always runs.
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle arm request.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = period (rise to rise), 1 = high width (rise to fall).
REQ-009 The block SHALL have port rd_ack, input, 1 bit: consumer acknowledge of a held result.
REQ-010 The block SHALL have port q, output, lpm_width bits: captured count.
REQ-011 The block SHALL have port valid, output, 1 bit: q holds a completed measurement.
REQ-012 The block SHALL have port busy, output, 1 bit: measurement armed or in progress.
REQ-013 The block SHALL have port overflow, output, 1 bit: count saturated during the held measurement.

Function
REQ-014 sig_in SHALL pass through lpm_sync_stages flops, plus one history flop; rise = sync 0->1, fall = sync 1->0, each a one-cycle internal event.
REQ-015 The FSM SHALL have exactly four states, IDLE, ARM, MEASURE and DONE; busy = (ARM or MEASURE).
REQ-016 In IDLE or DONE, start=1 SHALL go to ARM next cycle, latch mode into an internal mode register, and clear valid and overflow.
REQ-017 In ARM or MEASURE, start SHALL be ignored.
REQ-018 In ARM, a rise event SHALL go to MEASURE and load the counter with 0; other events are ignored.
REQ-019 In MEASURE, every cycle after the start edge with clk_en=1 SHALL add 1 to the counter, up to and including the terminating-edge cycle.
REQ-020 The terminating edge SHALL be a rise when latched mode=0 and a fall when latched mode=1.
REQ-021 On the terminating-edge cycle, q SHALL be loaded with the final count, valid SHALL be set, and the FSM SHALL go to DONE, all visible on the next clock edge.
REQ-022 Consequence of REQ-019: with clk_en tied high, a sig_in period of N clocks SHALL give q=N.
REQ-023 The counter SHALL saturate at all-ones; an increment attempted at all-ones SHALL leave the count at all-ones and set the overflow flag, which is reported with the result.
REQ-024 A saturated measurement SHALL still wait for the terminating edge; there is no timeout.
REQ-025 In DONE, q, valid and overflow SHALL hold until rd_ack=1 or start=1.
REQ-026 In DONE, rd_ack=1 with start=0 SHALL clear valid and go to IDLE, with q retaining its last value.
REQ-027 In DONE, start=1 together with rd_ack=1 SHALL let start win: go to ARM with valid cleared.
REQ-028 rd_ack outside DONE SHALL be ignored.
REQ-029 Changes to mode after arming SHALL have no effect until the next start.
REQ-030 With mode=1, a fall event seen in ARM SHALL be ignored, since the measurement starts only on a rise.
REQ-031 A terminating rise in mode=0 SHALL NOT rearm the block; a new start is required.

Reset
REQ-032 While aclr_n=0: state=IDLE, counter=0, synchronizer and history flops=0, q=0, valid=0, busy=0, overflow=0.
REQ-033 Reset SHALL take effect immediately, including mid-measurement; the partial count is discarded.
REQ-034 After aclr_n releases with sig_in already high, the resulting spurious rise SHALL be ignored because the state is IDLE.

Verification
REQ-035 Period scenario: mode=0, clk_en=1, start, sig_in square wave with 10-clock period -> q=10, valid=1, overflow=0, busy=0.
REQ-036 High-width scenario: mode=1, sig_in high for 7 clocks then low -> q=7, valid=1 one cycle after the synchronized fall.
REQ-037 clk_en scenario: clk_en=1 on alternate cycles, 20-clock period, mode=0 -> q=10.
REQ-038 Overflow scenario: lpm_width=4, period 40 clocks -> q=4'hF, overflow=1, valid=1.
REQ-039 Handshake scenario: in DONE, hold rd_ack=0 for 5 cycles -> q and valid stable; then rd_ack -> valid=0, IDLE; then start+rd_ack together in a later DONE -> ARM, busy=1, valid=0.
REQ-040 Reset scenario: aclr_n low mid-MEASURE -> all outputs 0 at once; after release with sig_in high -> busy stays 0 and valid stays 0.
